cv32e40x_xif_aes_result_buffer: RTL

// Result-side stage directly downstream of the AES32 functional unit on the XIF coprocessor path.

---
 rtl/cv32e40x_pkg.sv | 17 +
 rtl/cv32e40x_xif_commit_tracker.sv | 42 ++++
 rtl/cv32e40x_xif_aes_result_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types and sizing for the XIF AES result path.
package cv32e40x_pkg;

    localparam int XIF_AES_RESBUF_DEPTH = 4;
    localparam int XIF_AES_X_ID_WIDTH   = 4;
    localparam int XIF_AES_X_RFW_WIDTH  = 32;

    typedef struct packed {
        logic                           valid;
        logic                           committed;
        logic                           killed;
        logic [XIF_AES_X_ID_WIDTH-1:0]  id;
        logic [XIF_AES_X_RFW_WIDTH-1:0] data;
        logic [4:0]                     rd;
    } xif_aes_res_entry_t;

endpackage

// File: rtl/cv32e40x_xif_commit_tracker.sv
// Per-ID record of commits that arrived before their FU result; a slot is
// consumed (cleared) when the matching result enters the buffer.
module cv32e40x_xif_commit_tracker
    import cv32e40x_pkg::*;
#(
    parameter int X_ID_WIDTH = XIF_AES_X_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_i,
    input  logic [X_ID_WIDTH-1:0] set_id_i,
    input  logic                  set_kill_i,
    input  logic                  clr_i,
    input  logic [X_ID_WIDTH-1:0] lookup_id_i,
    output logic                  seen_o,
    output logic                  kill_o
);

    localparam int SLOTS = 2 ** X_ID_WIDTH;

    logic [SLOTS-1:0] seen_q;
    logic [SLOTS-1:0] kill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
            kill_q <= '0;
        end else begin
            if (clr_i) begin
                seen_q[lookup_id_i] <= 1'b0;
            end
            if (set_i) begin
                seen_q[set_id_i] <= 1'b1;
                kill_q[set_id_i] <= set_kill_i;
            end
        end
    end

    assign seen_o = seen_q[lookup_id_i];
    assign kill_o = kill_q[lookup_id_i];

endmodule

// File: rtl/cv32e40x_xif_aes_result_buffer.sv
// In-order result FIFO behind the AES32 unit: merges XIF commit/kill per ID
// and presents only committed, non-killed results on the XIF result channel.
module cv32e40x_xif_aes_result_buffer
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH       = XIF_AES_RESBUF_DEPTH,
    parameter int X_ID_WIDTH  = XIF_AES_X_ID_WIDTH,
    parameter int X_RFW_WIDTH = XIF_AES_X_RFW_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fu_valid_i,
    output logic                   fu_ready_o,
    input  logic [X_ID_WIDTH-1:0]  fu_id_i,
    input  logic [X_RFW_WIDTH-1:0] fu_data_i,
    input  logic [4:0]             fu_rd_i,
    input  logic                   commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]  commit_id_i,
    input  logic                   commit_kill_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [X_ID_WIDTH-1:0]  result_id_o,
    output logic [X_RFW_WIDTH-1:0] result_data_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o,
    output logic                   fifo_empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
    } payload_t;

    logic [DEPTH-1:0] valid_q, committed_q, killed_q;
    payload_t         payload_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q, count_q;

    logic [IDX_W-1:0] widx, ridx;
    logic             full, push, pop;
    logic             head_drop, head_present;
    logic             push_cmt, tbl_set, tbl_seen, tbl_kill;
    logic [DEPTH-1:0] hit_vec;
    logic             commit_hit, commit_dup, push_dup;

    assign widx = wptr_q[IDX_W-1:0];
    assign ridx = rptr_q[IDX_W-1:0];
    assign full = (count_q == PTR_W'(DEPTH));
    assign push = fu_valid_i && !full;

    // Killed heads retire silently; committed heads wait for result_ready_i.
    assign head_drop    = valid_q[ridx] && killed_q[ridx];
    assign head_present = valid_q[ridx] && committed_q[ridx] && !killed_q[ridx];
    assign pop          = head_drop || (head_present && result_ready_i);

    always_comb begin
        hit_vec    = '0;
        commit_dup = 1'b0;
        push_dup   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && payload_q[i].id == commit_id_i) begin
                hit_vec[i] = commit_valid_i;
                commit_dup = commit_dup || (commit_valid_i && committed_q[i]);
            end
            if (valid_q[i] && payload_q[i].id == fu_id_i && !(pop && IDX_W'(i) == ridx)) begin
                push_dup = push;
            end
        end
    end

    assign commit_hit = |hit_vec;
    assign push_cmt   = commit_valid_i && push && (commit_id_i == fu_id_i);
    assign tbl_set    = commit_valid_i && !commit_hit && !push_cmt;

    cv32e40x_xif_commit_tracker #(
        .X_ID_WIDTH (X_ID_WIDTH)
    ) commit_tracker_i (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (tbl_set),
        .set_id_i    (commit_id_i),
        .set_kill_i  (commit_kill_i),
        .clr_i       (push),
        .lookup_id_i (fu_id_i),
        .seen_o      (tbl_seen),
        .kill_o      (tbl_kill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            if (pop) begin
                valid_q[ridx] <= 1'b0;
                rptr_q        <= rptr_q + 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_vec[i]) begin
                    committed_q[i] <= 1'b1;
                    killed_q[i]    <= commit_kill_i;
                end
            end
            if (push) begin
                valid_q[widx]     <= 1'b1;
                committed_q[widx] <= tbl_seen || push_cmt;
                killed_q[widx]    <= (tbl_seen && tbl_kill) || (push_cmt && commit_kill_i);
                wptr_q            <= wptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            payload_q[widx] <= '{id: fu_id_i, data: fu_data_i, rd: fu_rd_i};
        end
    end

    assign fu_ready_o     = !full;
    assign fifo_empty_o   = (count_q == '0);
    assign result_valid_o = head_present;
    assign result_we_o    = head_present;
    assign result_id_o    = head_present ? payload_q[ridx].id   : '0;
    assign result_data_o  = head_present ? payload_q[ridx].data : '0;
    assign result_rd_o    = head_present ? payload_q[ridx].rd   : '0;

    a_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fu_valid_i |-> fu_ready_o);
    a_dup_inflight_id: assert property (@(posedge clk) disable iff (!rst_n)
        !push_dup);
    a_dup_commit: assert property (@(posedge clk) disable iff (!rst_n)
        !commit_dup);

endmodule
